countdown_mmss: RTL

COUNTDOWN_MMSS -- requirements
Module: countdown_mmss

---
 rtl/countdown_mmss.sv | 138 +++++++++++++
 1 files changed

// File: rtl/countdown_mmss.sv
// MM:SS BCD countdown timer with pause, load clamping and timed alarm; COUNTDOWN_AUTORELOAD_EN restarts from the loaded preset on expiry.
// Latency: load, start, pause and tick each take effect on outputs one clk edge later.
// Backpressure: none; inputs are sampled every cycle with priority reset > load > pause > start > tick.
module countdown_mmss #(
  parameter int ALARM_CYCLES = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [3:0] load_mt,
  input  logic [3:0] load_mu,
  input  logic [3:0] load_st,
  input  logic [3:0] load_su,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] mt,
  output logic [3:0] mu,
  output logic [3:0] st,
  output logic [3:0] su,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  state_t     state;
  logic [7:0] alarm_cnt;
  logic [3:0] c_mt, c_mu, c_st, c_su;
  logic [3:0] d_mt, d_mu, d_st, d_su;
  logic       time_zero;
  logic       time_one;

`ifdef COUNTDOWN_AUTORELOAD_EN
  logic [15:0] reload;
`endif

  // Clamp preset digits to a legal MM:SS value before latching.
  always_comb begin
    c_mt = (load_mt > 4'd9) ? 4'd9 : load_mt;
    c_mu = (load_mu > 4'd9) ? 4'd9 : load_mu;
    c_st = (load_st > 4'd5) ? 4'd5 : load_st;
    c_su = (load_su > 4'd9) ? 4'd9 : load_su;
  end

  assign time_zero = ({mt, mu, st, su} == 16'h0000);
  assign time_one  = ({mt, mu, st, su} == 16'h0001);

  // BCD decrement with borrow ripple su -> st -> mu -> mt.
  always_comb begin
    d_mt = mt;
    d_mu = mu;
    d_st = st;
    d_su = su;
    if (su != 4'd0) begin
      d_su = su - 4'd1;
    end else begin
      d_su = 4'd9;
      if (st != 4'd0) begin
        d_st = st - 4'd1;
      end else begin
        d_st = 4'd5;
        if (mu != 4'd0) begin
          d_mu = mu - 4'd1;
        end else begin
          d_mu = 4'd9;
          d_mt = mt - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mt        <= 4'd0;
      mu        <= 4'd0;
      st        <= 4'd0;
      su        <= 4'd0;
      running   <= 1'b0;
      done      <= 1'b0;
      alarm     <= 1'b0;
      alarm_cnt <= 8'd0;
`ifdef COUNTDOWN_AUTORELOAD_EN
      reload    <= 16'h0000;
`endif
    end else begin
      done <= 1'b0;
      // The alarm counter runs independently so it can overlap RUN after an auto-reload.
      if (alarm) begin
        if (alarm_cnt == 8'd0) alarm <= 1'b0;
        else alarm_cnt <= alarm_cnt - 8'd1;
      end

      if (load) begin
        {mt, mu, st, su} <= {c_mt, c_mu, c_st, c_su};
`ifdef COUNTDOWN_AUTORELOAD_EN
        reload    <= {c_mt, c_mu, c_st, c_su};
`endif
        state     <= IDLE;
        running   <= 1'b0;
        alarm     <= 1'b0;
        alarm_cnt <= 8'd0;
      end else if (pause && state == RUN) begin
        state   <= PAUSED;
        running <= 1'b0;
      end else if (start && (state == IDLE || state == PAUSED) && !time_zero) begin
        state   <= RUN;
        running <= 1'b1;
      end else if (tick && state == RUN) begin
        if (time_one) begin
          done      <= 1'b1;
          alarm     <= 1'b1;
          alarm_cnt <= 8'(ALARM_CYCLES - 1);
`ifdef COUNTDOWN_AUTORELOAD_EN
          if (reload != 16'h0000) begin
            {mt, mu, st, su} <= reload;
          end else begin
            {mt, mu, st, su} <= 16'h0000;
            state            <= EXPIRED;
            running          <= 1'b0;
          end
`else
          {mt, mu, st, su} <= 16'h0000;
          state            <= EXPIRED;
          running          <= 1'b0;
`endif
        end else begin
          {mt, mu, st, su} <= {d_mt, d_mu, d_st, d_su};
        end
      end else if (state == EXPIRED && alarm_cnt == 8'd0) begin
        state <= IDLE;
      end
    end
  end

endmodule
